// File: rtl/clkgen_pkg.sv
// ============================================================================
//  Module      : clkgen_pkg
//  Description : Shared types and constants for the clkgen_ctrl waveform
//                generator (FSM state encoding, configuration record).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package clkgen_pkg;

    localparam int CNT_W_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PHASE = 2'd1,
        ST_HIGH  = 2'd2,
        ST_LOW   = 2'd3
    } state_e;

    typedef struct packed {
        logic [CNT_W_DEF-1:0] period;
        logic [CNT_W_DEF-1:0] ton;
        logic [CNT_W_DEF-1:0] phase;
    } cfg_t;

endpackage

`default_nettype wire

// File: rtl/clkgen_dcnt.sv
// ============================================================================
//  Module      : clkgen_dcnt
//  Description : Loadable down-counter that stops at zero; load wins over en.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module clkgen_dcnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic         en_i,
    input  logic [W-1:0] load_val_i,
    output logic [W-1:0] value_o,
    output logic         zero_o
);

    logic [W-1:0] value_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value_q <= '0;
        end else if (load_i) begin
            value_q <= load_val_i;
        end else if (en_i && (value_q != '0)) begin
            value_q <= value_q - W'(1);
        end
    end

    assign value_o = value_q;
    assign zero_o  = (value_q == '0);

endmodule

`default_nettype wire

// File: rtl/clkgen_ctrl.sv
// ============================================================================
//  Module      : clkgen_ctrl
//  Description : Programmable clock/waveform generator with period, high time
//                and start phase. Optional CLKGEN_PERIOD_CNT_EN adds a
//                saturating 32-bit count of generated periods (period_cnt).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module clkgen_ctrl
    import clkgen_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CNT_W-1:0] cfg_period,
    input  logic [CNT_W-1:0] cfg_ton,
    input  logic [CNT_W-1:0] cfg_phase,
    output logic             cfg_err,
    input  logic             start,
    input  logic             stop,
    output logic             clk_out,
    output logic             busy
`ifdef CLKGEN_PERIOD_CNT_EN
    ,
    output logic [31:0]      period_cnt
`endif
);

    state_e           state_q, state_d;
    cfg_t             cfg_q;
    logic             cfg_loaded_q;
    logic             stop_pend_q;
    logic             cfg_ready_q;
    logic             cfg_err_q;
    logic             clk_out_q;

    logic             handshake;
    logic             cfg_ok;
    logic             start_go;
    logic             stop_seen;
    logic             cnt_load;
    logic             cnt_en;
    logic [CNT_W-1:0] cnt_load_val;
    logic [CNT_W-1:0] cnt_value;
    logic             cnt_zero;
    logic [CNT_W-1:0] ton_m1;
    logic [CNT_W-1:0] low_m1;
    logic [CNT_W-1:0] phase_m1;

    assign handshake = cfg_valid && cfg_ready_q;
    assign cfg_ok    = (cfg_period >= CNT_W'(2)) && (cfg_ton >= CNT_W'(1)) &&
                       (cfg_ton <= (cfg_period - CNT_W'(1)));
    // A coinciding handshake or stop suppresses start.
    assign start_go  = (state_q == ST_IDLE) && start && !stop && cfg_loaded_q && !handshake;
    assign stop_seen = stop_pend_q || stop;

    // Reload values are count-1 so the counter only ever runs down to zero.
    assign ton_m1    = CNT_W'(cfg_q.ton) - CNT_W'(1);
    assign low_m1    = CNT_W'(cfg_q.period) - CNT_W'(cfg_q.ton) - CNT_W'(1);
    assign phase_m1  = CNT_W'(cfg_q.phase) - CNT_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            clk_out_q   <= 1'b0;
            cfg_ready_q <= 1'b0;
            cfg_err_q   <= 1'b0;
            stop_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            clk_out_q   <= (state_d == ST_HIGH);
            cfg_ready_q <= (state_d == ST_IDLE);
            cfg_err_q   <= handshake && !cfg_ok;
            stop_pend_q <= (state_d == ST_IDLE) ? 1'b0 : (stop_pend_q || (busy && stop));
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        case (state_q)
            ST_IDLE: begin
                if (start_go) begin
                    cnt_load = 1'b1;
                    if (cfg_q.phase == '0) begin
                        state_d      = ST_HIGH;
                        cnt_load_val = ton_m1;
                    end else begin
                        state_d      = ST_PHASE;
                        cnt_load_val = phase_m1;
                    end
                end
            end
            ST_PHASE: begin
                if (stop_seen) begin
                    state_d = ST_IDLE;
                end else if (cnt_zero) begin
                    state_d      = ST_HIGH;
                    cnt_load     = 1'b1;
                    cnt_load_val = ton_m1;
                end
            end
            ST_HIGH: begin
                if (cnt_zero) begin
                    state_d      = ST_LOW;
                    cnt_load     = 1'b1;
                    cnt_load_val = low_m1;
                end
            end
            ST_LOW: begin
                if (cnt_zero) begin
                    if (stop_seen) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d      = ST_HIGH;
                        cnt_load     = 1'b1;
                        cnt_load_val = ton_m1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy      = (state_q != ST_IDLE);
        cnt_en    = busy && (cnt_value != '0);
        cfg_ready = cfg_ready_q;
        cfg_err   = cfg_err_q;
        clk_out   = clk_out_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cfg_q        <= '0;
            cfg_loaded_q <= 1'b0;
        end else if (handshake && cfg_ok) begin
            cfg_q.period <= CNT_W_DEF'(cfg_period);
            cfg_q.ton    <= CNT_W_DEF'(cfg_ton);
            cfg_q.phase  <= CNT_W_DEF'(cfg_phase);
            cfg_loaded_q <= 1'b1;
        end
    end

    clkgen_dcnt #(
        .W (CNT_W)
    ) u_dcnt (
        .clk        (clk),
        .rst        (rst),
        .load_i     (cnt_load),
        .en_i       (cnt_en),
        .load_val_i (cnt_load_val),
        .value_o    (cnt_value),
        .zero_o     (cnt_zero)
    );

`ifdef CLKGEN_PERIOD_CNT_EN
    logic [31:0] period_cnt_q;

    // A start that enters HIGH directly already counts as the first period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            period_cnt_q <= '0;
        end else if (start_go) begin
            period_cnt_q <= (state_d == ST_HIGH) ? 32'd1 : 32'd0;
        end else if ((state_d == ST_HIGH) && (state_q != ST_HIGH) && (period_cnt_q != '1)) begin
            period_cnt_q <= period_cnt_q + 32'd1;
        end
    end

    assign period_cnt = period_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_clkgen_ctrl.sv
// ============================================================================
//  Module      : tb_clkgen_ctrl
//  Description : Self-checking bench for clkgen_ctrl (table vectors plus
//                hand-written multi-cycle sequences).
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_clkgen_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [15:0] cfg_period;
    logic [15:0] cfg_ton;
    logic [15:0] cfg_phase;
    logic        cfg_err;
    logic        start;
    logic        stop;
    logic        clk_out;
    logic        busy;
`ifdef CLKGEN_PERIOD_CNT_EN
    logic [31:0] period_cnt;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    clkgen_ctrl #(.CNT_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_period (cfg_period),
        .cfg_ton    (cfg_ton),
        .cfg_phase  (cfg_phase),
        .cfg_err    (cfg_err),
        .start      (start),
        .stop       (stop),
        .clk_out    (clk_out),
        .busy       (busy)
`ifdef CLKGEN_PERIOD_CNT_EN
        ,
        .period_cnt (period_cnt)
`endif
    );

    typedef struct {
        string       name;
        logic        v;
        logic [15:0] per;
        logic [15:0] ton;
        logic [15:0] ph;
        logic        st;
        logic        sp;
        logic        e_rdy;
        logic        e_err;
        logic        e_clk;
        logic        e_busy;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input string n, input logic v, input int per, input int ton, input int ph,
                       input logic st, input logic sp, input logic rdy, input logic err,
                       input logic ck, input logic bz);
        vec_t x;
        x.name = n; x.v = v; x.per = 16'(per); x.ton = 16'(ton); x.ph = 16'(ph);
        x.st = st; x.sp = sp; x.e_rdy = rdy; x.e_err = err; x.e_clk = ck; x.e_busy = bz;
        vecs.push_back(x);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        cfg_valid = 1'b0; start = 1'b0; stop = 1'b0;
    endtask

    task automatic load_cfg(input int per, input int ton, input int ph);
        cfg_valid = 1'b1; cfg_period = 16'(per); cfg_ton = 16'(ton); cfg_phase = 16'(ph);
        step();
        cfg_valid = 1'b0;
        check("cfg_accept_err", 32'(cfg_err), 32'd0);
    endtask

    initial begin
        int  n;
        logic seen_high;
        rst = 1'b1; cfg_period = '0; cfg_ton = '0; cfg_phase = '0;
        idle_inputs();

        // Reset-state check without relying on a clock edge
        #12;
        check("rst_clk_out", 32'(clk_out), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_cfg_err", 32'(cfg_err), 32'd0);
        check("rst_cfg_ready", 32'(cfg_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("ready_before_edge", 32'(cfg_ready), 32'd0);
        step();
        check("ready_after_rel", 32'(cfg_ready), 32'd1);

        // name, v, per, ton, ph, st, sp | rdy, err, clk, busy
        add("rej_4_4",       1, 4, 4, 0, 0, 0, 1, 1, 0, 0);
        add("start_unload",  0, 0, 0, 0, 1, 0, 1, 0, 0, 0);
        add("idle_hold",     0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        add("rej_1_0",       1, 1, 0, 0, 0, 0, 1, 1, 0, 0);
        add("rej_2_0",       1, 2, 0, 0, 0, 0, 1, 1, 0, 0);
        add("rej_3_3",       1, 3, 3, 0, 0, 0, 1, 1, 0, 0);
        add("acc_2_1",       1, 2, 1, 0, 0, 0, 1, 0, 0, 0);
        add("cfg_with_start",1, 10, 1, 2, 1, 0, 1, 0, 0, 0);
        add("start_phase0",  0, 0, 0, 0, 1, 0, 0, 0, 0, 1);
        add("phase1",        0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        add("high1",         1, 4, 4, 0, 0, 0, 0, 0, 1, 1);
        for (int i = 0; i < 9; i++)
            add("low_a",     0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        add("high2",         0, 0, 0, 0, 1, 0, 0, 0, 1, 1);
        add("low_b",         0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

        foreach (vecs[i]) begin
            cfg_valid = vecs[i].v; cfg_period = vecs[i].per; cfg_ton = vecs[i].ton;
            cfg_phase = vecs[i].ph; start = vecs[i].st; stop = vecs[i].sp;
            step();
            check({vecs[i].name, "/ready"}, 32'(cfg_ready), 32'(vecs[i].e_rdy));
            check({vecs[i].name, "/err"},   32'(cfg_err),   32'(vecs[i].e_err));
            check({vecs[i].name, "/clk"},   32'(clk_out),   32'(vecs[i].e_clk));
            check({vecs[i].name, "/busy"},  32'(busy),      32'(vecs[i].e_busy));
        end
        idle_inputs();

        // Reset mid-HIGH: outputs drop at once, config is forgotten
        n = 0;
        while (!clk_out && n < 30) begin step(); n++; end
        check("wait_high", 32'(clk_out), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_clk", 32'(clk_out), 32'd0);
        check("async_rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        step();
        check("rst_ready", 32'(cfg_ready), 32'd1);
        start = 1'b1; step(); start = 1'b0;
        check("start_no_cfg", 32'(busy), 32'd0);
        step();
        check("start_no_cfg2", 32'(busy), 32'd0);

        // period 8, ton 4, phase 0; stop in the 2nd HIGH cycle
        load_cfg(8, 4, 0);
        start = 1'b1; step(); start = 1'b0;
        check("ph0_high_now", 32'(clk_out), 32'd1);
        step();
        check("high_c2", 32'(clk_out), 32'd1);
        stop = 1'b1; step(); stop = 1'b0;
        check("high_c3", 32'(clk_out), 32'd1);
        step();
        check("high_c4", 32'(clk_out), 32'd1);
        for (int i = 0; i < 4; i++) begin
            step();
            check("stop_low", 32'({clk_out, busy}), 32'b01);
        end
        step();
        check("stop_idle_busy", 32'(busy), 32'd0);
        check("stop_idle_clk", 32'(clk_out), 32'd0);
        check("stop_idle_ready", 32'(cfg_ready), 32'd1);

        // stop and start together in IDLE: neither acts, nothing pends
        stop = 1'b1; start = 1'b1; step(); idle_inputs();
        check("stop_start_idle", 32'(busy), 32'd0);
        step();
        check("stop_start_idle2", 32'(busy), 32'd0);

        // stop during PHASE aborts and clk_out never rises
        load_cfg(8, 4, 5);
        start = 1'b1; step(); start = 1'b0;
        check("phase_busy", 32'({clk_out, busy}), 32'b01);
        stop = 1'b1; step(); stop = 1'b0;
        check("phase_abort", 32'(busy), 32'd0);
        seen_high = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (clk_out) seen_high = 1'b1;
        end
        check("phase_abort_noclk", 32'(seen_high), 32'd0);

`ifdef CLKGEN_PERIOD_CNT_EN
        load_cfg(2, 1, 0);
        start = 1'b1; step(); start = 1'b0;
        for (int i = 0; i < 19; i++) step();
        check("period_cnt_10", period_cnt, 32'd10);
        stop = 1'b1; step(); stop = 1'b0;
        n = 0;
        while (busy && n < 10) begin step(); n++; end
        check("pcnt_stop_idle", 32'(busy), 32'd0);
        load_cfg(2, 1, 3);
        start = 1'b1; step(); start = 1'b0;
        check("period_cnt_clr", period_cnt, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
